// File: rtl/ring_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ring_rr_arbiter_pkg
// Shared definitions for the ring round-robin arbiter:
//   state_e    - arbiter FSM states (IDLE, GRANT)
//   clog2      - constant ceil(log2) used to size gnt_id and the hold counter
//   params_ok  - legality check on N / MAX_HOLD, evaluated at elaboration
// ----------------------------------------------------------------------------
package ring_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

    // N must be at least 2 and MAX_HOLD at least 1.
    function automatic bit params_ok(input int n, input int max_hold);
        return (n >= 2) && (max_hold >= 1);
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// ring_rr_arbiter_if
// Request/grant bundle between the requesting engines and the arbiter.
//   en        - arbiter enable (requester side drives)
//   req[N]    - level-sensitive requests
//   gnt[N]    - registered one-hot / all-zero grant
//   gnt_valid - |gnt
//   gnt_id    - binary index of the granted requester (0 when idle)
//   ptr[N]    - one-hot ring priority pointer
//   preempt   - one-cycle pulse on a forced release at MAX_HOLD
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface ring_rr_arbiter_if
    import ring_rr_arbiter_pkg::*;
#(
    parameter int N = 4
);
    localparam int IW = clog2(N);

    logic          en;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic [N-1:0]  ptr;
    logic          preempt;

    modport master (
        output en, req,
        input  gnt, gnt_valid, gnt_id, ptr, preempt
    );

    modport slave (
        input  en, req,
        output gnt, gnt_valid, gnt_id, ptr, preempt
    );

endinterface

// File: rtl/ring_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search.
//   ptr[N]     - one-hot start position of the scan
//   req[N]     - request vector
//   win_oh[N]  - one-hot winner (0 when no request)
//   win_idx    - binary index of the winner (0 when no request)
//   win_any    - at least one request present
// The request vector is doubled; the lower copy is masked to positions at or
// above ptr, so the first set bit of the doubled vector is the first request
// found scanning from ptr upward with wrap-around.
// ----------------------------------------------------------------------------
module rr_pick
    import ring_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  ptr,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          win_any
);

    logic [N-1:0]   mask_lo;
    logic [2*N-1:0] dbl;

    // ~(ptr - 1) sets every bit at or above the one-hot pointer position.
    assign mask_lo = ~(ptr - N'(1));
    assign dbl     = {req, req & mask_lo};
    assign win_any = |req;

    always_comb begin
        logic found;
        found   = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found             = 1'b1;
                win_oh[i % N]     = 1'b1;
                win_idx           = IW'(i % N);
            end
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ring_rr_arbiter
// Round-robin arbiter with a one-hot rotating ring pointer and a per-grant
// hold cap of MAX_HOLD cycles.
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - ring_rr_arbiter_if.slave (en, req in; gnt, gnt_valid, gnt_id,
//          ptr, preempt out)
// A grant is held while the owner keeps requesting and en stays high, up to
// MAX_HOLD cycles. Every release rotates ptr one position past the owner and
// leaves one idle cycle before the next grant.
// ----------------------------------------------------------------------------
module ring_rr_arbiter
    import ring_rr_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input logic               clk,
    input logic               rst,
    ring_rr_arbiter_if.slave  bus
);

    localparam int IW = clog2(N);
    localparam int HW = clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE  = ST_IDLE;
    localparam logic [0:0] GRANT = ST_GRANT;

    if (!params_ok(N, MAX_HOLD)) begin : g_param_check
        $error("ring_rr_arbiter: N must be >= 2 and MAX_HOLD >= 1");
    end

    logic [0:0]    state_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gid_q;
    logic [N-1:0]  ptr_q;
    logic [HW-1:0] hold_q;
    logic          pre_q;

    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          owner_req;
    logic          hold_max;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .ptr     (ptr_q),
        .req     (bus.req),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

    assign owner_req = bus.req[gid_q];
    assign hold_max  = (hold_q == HW'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gid_q   <= '0;
            ptr_q   <= N'(1);
            hold_q  <= '0;
            pre_q   <= 1'b0;
        end else begin
            pre_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.en && pick_any) begin
                        gnt_q   <= pick_oh;
                        gid_q   <= pick_idx;
                        hold_q  <= HW'(1);
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.en || !owner_req || hold_max) begin
                        gnt_q   <= '0;
                        gid_q   <= '0;
                        hold_q  <= '0;
                        state_q <= IDLE;
                        // Rotating the one-hot grant yields onehot(owner+1).
                        ptr_q   <= {gnt_q[N-2:0], gnt_q[N-1]};
                        // Only a cap-driven release counts as preemption.
                        pre_q   <= bus.en && owner_req;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = |gnt_q;
    assign bus.gnt_id    = gid_q;
    assign bus.ptr       = ptr_q;
    assign bus.preempt   = pre_q;

endmodule
